// File: rtl/core_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master) and
// the memory subsystem (slave).
interface core_sequencer_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_data_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rd_data_in;

  modport master (
    output imem_req_out, imem_addr_out, dmem_req_out, dmem_we_out,
    input  imem_ack_in, imem_data_in, dmem_ack_in, dmem_rd_data_in
  );

  modport slave (
    input  imem_req_out, imem_addr_out, dmem_req_out, dmem_we_out,
    output imem_ack_in, imem_data_in, dmem_ack_in, dmem_rd_data_in
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access and
// writeback, with halt at instruction boundaries and a sticky trap state.
//
// state | meaning
// FETCH | request instruction at pc, wait for imem ack
// EXEC  | one-cycle opcode classification
// MEM   | load/store access, wait for dmem ack
// WB    | commit pc and instret, pulse register write
// HALT  | paused at instruction boundary until halt_in drops
// TRAP  | fault; outputs quiet until reset
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  core_sequencer_if.master        mem,
  output logic [31:0]             instr_out,
  output logic [31:0]             pc_out,
  input  logic [31:0]             pc_next_in,
  input  logic                    ctrl_reg_wr_en_in,
  output logic                    reg_wr_en_out,
  output logic [31:0]             load_data_out,
  input  logic                    halt_in,
  output logic                    trap_out,
  output logic [2:0]              state_out,
  output logic [31:0]             instret_out
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_TRAP  = 3'd5
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] load_q;
  logic [31:0] instret_q;
  logic        trap_q;

  logic [6:0]  opcode;
  logic        op_valid;
  logic        op_mem;
  logic        op_store;
  logic        pc_misaligned;

  assign opcode        = instr_q[6:0];
  assign op_store      = (opcode == OP_STORE);
  assign op_mem        = (opcode == OP_LOAD) || op_store;
  assign pc_misaligned = (pc_next_in[1:0] != 2'b00);

  always_comb begin
    op_valid = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: op_valid = 1'b1;
      default:                                        op_valid = 1'b0;
    endcase
  end

  // Strobes decode the registered state and are held low throughout reset.
  assign mem.imem_req_out  = !rst && (state_q == ST_FETCH);
  assign mem.imem_addr_out = pc_q;
  assign mem.dmem_req_out  = !rst && (state_q == ST_MEM);
  assign mem.dmem_we_out   = !rst && (state_q == ST_MEM) && op_store;
  assign reg_wr_en_out     = !rst && (state_q == ST_WB) && !pc_misaligned && ctrl_reg_wr_en_in;

  assign instr_out     = instr_q;
  assign pc_out        = pc_q;
  assign load_data_out = load_q;
  assign instret_out   = instret_q;
  assign trap_out      = trap_q;
  assign state_out     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0013;
      load_q    <= 32'h0000_0000;
      instret_q <= 32'h0000_0000;
      trap_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem.imem_ack_in) begin
            instr_q <= mem.imem_data_in;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!op_valid) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
          end else if (op_mem) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem.dmem_ack_in) begin
            if (!op_store) load_q <= mem.dmem_rd_data_in;
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          if (pc_misaligned) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
          end else begin
            pc_q      <= pc_next_in;
            instret_q <= instret_q + 32'd1;
            state_q   <= halt_in ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          if (!halt_in) state_q <= ST_FETCH;
        end
        ST_TRAP: begin
          trap_q <= 1'b1;
        end
        default: begin
          state_q <= ST_TRAP;
          trap_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: the driver plays memory and
// queues expected retirements; a monitor checks each writeback as it appears.
module tb_core_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_out, pc_out, pc_next_in, load_data_out, instret_out;
  logic        ctrl_reg_wr_en_in, reg_wr_en_out, halt_in, trap_out;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  core_sequencer_if bus();

  core_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem               (bus),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .pc_next_in        (pc_next_in),
    .ctrl_reg_wr_en_in (ctrl_reg_wr_en_in),
    .reg_wr_en_out     (reg_wr_en_out),
    .load_data_out     (load_data_out),
    .halt_in           (halt_in),
    .trap_out          (trap_out),
    .state_out         (state_out),
    .instret_out       (instret_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_before;
    logic [31:0] pc_after;
    logic [31:0] instret_after;
    logic [31:0] load_exp;
    logic        wr;
    int          ireq;
    int          dreq;
    int          dwe;
    int          cycles;
    logic [31:0] state_after;
  } exp_t;

  exp_t sb_q[$];

  int vectors = 0;
  int errors  = 0;

  // Reference model state: architectural view only.
  logic [31:0] m_pc, m_instret, m_load;
  int          m_halt_prev;

  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_pc        = RESET_PC;
    m_instret   = 32'd0;
    m_load      = 32'd0;
    m_halt_prev = 0;
  endtask

  // ---------------- monitor ----------------
  int          mon_cyc = 0, mon_ireq = 0, mon_dreq = 0, mon_dwe = 0;
  logic        mon_seen_addr = 1'b0;
  logic [31:0] mon_addr = 32'd0;
  bit          post_pend = 0;
  exp_t        post_e;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_cyc = 0; mon_ireq = 0; mon_dreq = 0; mon_dwe = 0;
        mon_seen_addr = 1'b0;
        post_pend = 0;
      end else begin
        if (post_pend) begin
          check("pc_after_wb", pc_out, post_e.pc_after);
          check("instret_after_wb", instret_out, post_e.instret_after);
          check("state_after_wb", 32'(state_out), post_e.state_after);
          post_pend = 0;
        end
        mon_cyc++;
        mon_ireq += int'(bus.imem_req_out);
        mon_dreq += int'(bus.dmem_req_out);
        mon_dwe  += int'(bus.dmem_we_out);
        if (bus.imem_req_out && !mon_seen_addr) begin
          mon_addr = bus.imem_addr_out;
          mon_seen_addr = 1'b1;
        end
        if (state_out == 3'd3) begin
          if (sb_q.size() == 0) begin
            check("wb_without_expectation", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("wb_instr", instr_out, e.instr);
            check("wb_reg_wr_en", 32'(reg_wr_en_out), 32'(e.wr));
            check("wb_load_data", load_data_out, e.load_exp);
            check("wb_pc", pc_out, e.pc_before);
            check("fetch_addr", mon_addr, e.pc_before);
            check("imem_req_cycles", 32'(mon_ireq), 32'(e.ireq));
            check("dmem_req_cycles", 32'(mon_dreq), 32'(e.dreq));
            check("dmem_we_cycles", 32'(mon_dwe), 32'(e.dwe));
            check("latency", 32'(mon_cyc), 32'(e.cycles));
            post_e = e;
            post_pend = 1;
          end
          mon_cyc = 0; mon_ireq = 0; mon_dreq = 0; mon_dwe = 0;
          mon_seen_addr = 1'b0;
        end
      end
    end
  end

  // ---------------- driver / memory responder ----------------
  task automatic wait_fetch();
    int n = 0;
    while (!bus.imem_req_out && n < 40) begin
      step();
      n++;
    end
    check("fetch_req_seen", 32'(bus.imem_req_out), 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input int h,
                           input logic [31:0] pcn, input logic wr, input logic [31:0] mdata);
    exp_t e;
    logic [6:0] op = instr[6:0];
    bit is_mem   = (op == OP_LOAD) || (op == OP_STORE);
    bit is_store = (op == OP_STORE);
    bit mis      = (pcn[1:0] != 2'b00);

    e.instr     = instr;
    e.pc_before = m_pc;
    e.ireq      = fw + 1;
    e.dreq      = is_mem ? mw + 1 : 0;
    e.dwe       = is_store ? mw + 1 : 0;
    e.cycles    = m_halt_prev + (fw + 1) + 1 + (is_mem ? mw + 1 : 0) + 1;
    if (is_mem && !is_store) m_load = mdata;
    e.load_exp  = m_load;
    if (mis) begin
      e.wr          = 1'b0;
      e.state_after = 32'd5;
      m_halt_prev   = 0;
    end else begin
      e.wr          = wr;
      m_pc          = pcn;
      m_instret     = m_instret + 32'd1;
      e.state_after = (h > 0) ? 32'd4 : 32'd0;
      m_halt_prev   = h;
    end
    e.pc_after      = m_pc;
    e.instret_after = m_instret;
    sb_q.push_back(e);

    pc_next_in        = pcn;
    ctrl_reg_wr_en_in = wr;
    halt_in           = (h > 0);
    bus.imem_data_in  = instr;
    wait_fetch();
    repeat (fw) begin
      bus.imem_ack_in     = 1'b0;
      bus.dmem_ack_in     = 1'($urandom_range(0, 1));
      bus.dmem_rd_data_in = $urandom();
      step();
    end
    bus.imem_ack_in = 1'b1;
    bus.dmem_ack_in = 1'b0;
    step();
    // EXEC: spurious fetch acks with garbage must not disturb the latched word
    bus.imem_ack_in  = 1'($urandom_range(0, 1));
    bus.imem_data_in = $urandom();
    if (is_mem) begin
      step();
      repeat (mw) begin
        bus.dmem_ack_in = 1'b0;
        bus.imem_ack_in = 1'($urandom_range(0, 1));
        step();
      end
      bus.dmem_ack_in     = 1'b1;
      bus.dmem_rd_data_in = mdata;
      step();
    end else begin
      step();
    end
    bus.dmem_ack_in = 1'b0;
    bus.imem_ack_in = 1'b0;
    if (mis) begin
      halt_in = 1'b0;
      step();
    end else if (h > 0) begin
      repeat (h) step();
      halt_in = 1'b0;
      step();
    end else begin
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_out), 32'd0);
    check({tag, "_pc"}, pc_out, RESET_PC);
    check({tag, "_instr"}, instr_out, 32'h0000_0013);
    check({tag, "_load"}, load_data_out, 32'd0);
    check({tag, "_instret"}, instret_out, 32'd0);
    check({tag, "_trap"}, 32'(trap_out), 32'd0);
    check({tag, "_imem_req"}, 32'(bus.imem_req_out), 32'd0);
    check({tag, "_dmem_req"}, 32'(bus.dmem_req_out), 32'd0);
    check({tag, "_dmem_we"}, 32'(bus.dmem_we_out), 32'd0);
    check({tag, "_reg_wr"}, 32'(reg_wr_en_out), 32'd0);
  endtask

  task automatic check_trapped(input string tag, input int cycles);
    repeat (cycles) begin
      ctrl_reg_wr_en_in   = 1'b1;
      pc_next_in          = {$urandom_range(0, 255), 2'b00};
      halt_in             = 1'($urandom_range(0, 1));
      bus.imem_ack_in     = 1'($urandom_range(0, 1));
      bus.dmem_ack_in     = 1'($urandom_range(0, 1));
      step();
      check({tag, "_trap"}, 32'(trap_out), 32'd1);
      check({tag, "_state"}, 32'(state_out), 32'd5);
      check({tag, "_imem_req"}, 32'(bus.imem_req_out), 32'd0);
      check({tag, "_dmem_req"}, 32'(bus.dmem_req_out), 32'd0);
      check({tag, "_reg_wr"}, 32'(reg_wr_en_out), 32'd0);
      check({tag, "_pc"}, pc_out, m_pc);
      check({tag, "_instret"}, instret_out, m_instret);
    end
    bus.imem_ack_in = 1'b0;
    bus.dmem_ack_in = 1'b0;
    halt_in         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int fw, mw, h;
    bus.imem_ack_in     = 1'b0;
    bus.imem_data_in    = 32'd0;
    bus.dmem_ack_in     = 1'b0;
    bus.dmem_rd_data_in = 32'd0;
    pc_next_in          = 32'd4;
    ctrl_reg_wr_en_in   = 1'b1;
    halt_in             = 1'b0;
    rst                 = 1'b1;
    model_reset();
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;

    // ADDI, LW with two wait cycles, SW leaving load data alone
    run_instr(32'h0050_0093, 0, 0, 0, RESET_PC + 32'd4, 1'b1, 32'd0);
    run_instr(32'h0000_a103, 1, 2, 0, RESET_PC + 32'd8, 1'b1, 32'hDEAD_BEEF);
    run_instr(32'h0020_a023, 0, 1, 0, RESET_PC + 32'hC, 1'b0, 32'h1234_5678);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom();
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      h  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      run_instr({r[31:7], ops[$urandom_range(0, 8)]}, fw, mw, h,
                {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'($urandom_range(0, 1)), $urandom());
    end

    // instret wrap during a 5-cycle halt
    dut.instret_q = 32'hFFFF_FFFF;
    m_instret     = 32'hFFFF_FFFF;
    run_instr(32'h0010_0113, 0, 0, 5, 32'h0000_2000, 1'b1, 32'd0);
    run_instr(32'h0000_0237, 1, 0, 0, 32'h0000_2004, 1'b1, 32'd0);

    // misaligned next pc traps in WB
    run_instr(32'h0080_00EF, 0, 0, 0, 32'h0000_0102, 1'b1, 32'd0);
    check_trapped("misalign_trap", 4);
    check("sb_drained_misalign", 32'(sb_q.size()), 32'd0);

    rst = 1'b1;
    step();
    check_reset_vals("reset_after_trap");
    rst = 1'b0;
    model_reset();

    // illegal all-zero instruction
    wait_fetch();
    bus.imem_data_in = 32'h0000_0000;
    bus.imem_ack_in  = 1'b1;
    step();
    bus.imem_ack_in  = 1'b0;
    check("illegal_exec_state", 32'(state_out), 32'd1);
    check("illegal_exec_trap", 32'(trap_out), 32'd0);
    step();
    check_trapped("illegal_trap", 4);

    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();

    // reset in the middle of a fetch wait
    run_instr(32'h0000_0517, 0, 0, 0, 32'h0000_4000, 1'b1, 32'd0);
    wait_fetch();
    check("midreq_addr_before", bus.imem_addr_out, 32'h0000_4000);
    step();
    rst = 1'b1;
    step();
    check("midreq_imem_req_in_rst", 32'(bus.imem_req_out), 32'd0);
    rst = 1'b0;
    model_reset();
    step();
    check("midreq_refetch_addr", bus.imem_addr_out, RESET_PC);
    check("midreq_refetch_req", 32'(bus.imem_req_out), 32'd1);
    run_instr(32'h0000_8067, 2, 0, 0, 32'h0000_0200, 1'b0, 32'd0);
    step();
    step();
    check("sb_drained_final", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req_out  output  1  instruction fetch request.
REQ-005 SHALL have port imem_addr_out  output  32  fetch address, equal to pc_out.
REQ-006 SHALL have port imem_ack_in  input  1  fetch complete; imem_data_in valid this cycle.
REQ-007 SHALL have port imem_data_in  input  32  fetched instruction word.
REQ-008 SHALL have port instr_out  output  32  latched instruction, driven to the decode/control datapath.
REQ-009 SHALL have port pc_out  output  32  architectural PC register.
REQ-010 SHALL have port pc_next_in  input  32  next PC computed by the control datapath.
REQ-011 SHALL have port ctrl_reg_wr_en_in  input  1  datapath register-write intent.
REQ-012 SHALL have port reg_wr_en_out  output  1  gated register-file write enable.
REQ-013 SHALL have port dmem_req_out  output  1  data memory request.
REQ-014 SHALL have port dmem_we_out  output  1  data memory write (store) qualifier.
REQ-015 SHALL have port dmem_ack_in  input  1  data access complete; dmem_rd_data_in valid this cycle.
REQ-016 SHALL have port dmem_rd_data_in  input  32  raw load data from memory.
REQ-017 SHALL have port load_data_out  output  32  latched load data, driven to the control datapath.
REQ-018 SHALL have port halt_in  input  1  request to pause at the next instruction boundary.
REQ-019 SHALL have port trap_out  output  1  sticky fault indicator.
REQ-020 SHALL have port state_out  output  3  current FSM state encoding.
REQ-021 SHALL have port instret_out  output  32  retired-instruction counter.

Function
REQ-022 SHALL implement states FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4, TRAP=5; codes 6-7 unreachable, and SHALL go to TRAP if ever entered.
REQ-023 FETCH: imem_req_out=1; request held stable until imem_ack_in; on ack, instr_out<=imem_data_in, go EXEC; ack in same cycle as request counts.
REQ-024 EXEC: exactly one cycle; opcode instr_out[6:0] not in {0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111} -> TRAP; 0000011 or 0100011 -> MEM; else -> WB.
REQ-025 MEM: dmem_req_out=1; dmem_we_out=1 iff opcode 0100011; held until dmem_ack_in; on ack, load_data_out<=dmem_rd_data_in (loads only, stores leave it unchanged), go WB.
REQ-026 WB: if pc_next_in[1:0]!=2'b00 -> TRAP, PC/instret unchanged, reg_wr_en_out=0.
REQ-027 WB, aligned: reg_wr_en_out=ctrl_reg_wr_en_in for this one cycle; pc_out<=pc_next_in; instret_out<=instret_out+1 (mod 2^32, wraps to 0); next state HALT if halt_in else FETCH.
REQ-028 HALT: no requests; return to FETCH in the cycle after halt_in is sampled low.
REQ-029 TRAP: trap_out=1, all requests and reg_wr_en_out 0, remain until rst.
REQ-030 reg_wr_en_out, imem_req_out, dmem_req_out, dmem_we_out SHALL be 0 in every state/cycle not listed above.
REQ-031 imem_ack_in outside FETCH and dmem_ack_in outside MEM SHALL be ignored.
REQ-032 halt_in SHALL only be sampled in WB and HALT; it never aborts an in-flight request.
REQ-033 Latency: non-memory instruction 3 cycles minimum (FETCH, EXEC, WB); load/store 4 minimum; each wait cycle adds one.

Reset
REQ-034 While rst=1 at a rising edge: state<=FETCH, pc_out<=RESET_PC, instr_out<=32'h0000_0013, load_data_out<=0, instret_out<=0, trap_out<=0.
REQ-035 While rst=1, imem_req_out, dmem_req_out, dmem_we_out, reg_wr_en_out SHALL be forced 0.
REQ-036 rst mid-request SHALL abandon the transaction; first fetch after release is from RESET_PC.

Verification
REQ-037 ADDI at 0x0, ack same cycle, pc_next_in=0x4 -> states 0,1,3,0; reg_wr_en_out one cycle in WB; pc_out=0x4; instret_out=1.
REQ-038 LW, dmem_ack_in after 2 wait cycles, data 0xDEADBEEF -> dmem_req_out high 3 cycles, dmem_we_out=0, load_data_out=0xDEADBEEF, then WB.
REQ-039 SW -> dmem_we_out=1 during MEM only; load_data_out unchanged; reg_wr_en_out=ctrl_reg_wr_en_in (0).
REQ-040 Instruction 0x0000_0000 fetched -> TRAP after EXEC, trap_out=1, no writes; only rst clears it.
REQ-041 JAL with pc_next_in=0x0000_0102 -> TRAP in WB, pc_out and instret_out unchanged, reg_wr_en_out=0.
REQ-042 halt_in=1 during WB for 5 cycles -> HALT, no imem_req_out; preset instret_out=32'hFFFF_FFFF retires -> 0.
